// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of fetched words plus prediction metadata.
// Optional macro IQ_BYPASS_EN lets an instruction reach decode in the same cycle when the queue is empty.
module inst_queue #(
    parameter int DEPTH     = 16,
    parameter int BHT_IDX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_inst,
    input  logic [BHT_IDX_W-1:0]     enq_bht_idx,
    input  logic                     enq_pred_taken,
    input  logic [31:0]              enq_pred_target,
    output logic                     iq_valid,
    input  logic                     iq_ready,
    output logic [31:0]              iq_pc,
    output logic [31:0]              iq_inst,
    output logic [BHT_IDX_W-1:0]     iq_bht_idx,
    output logic                     iq_pred_taken,
    output logic [31:0]              iq_pred_target,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [BHT_IDX_W-1:0] bht_idx;
        logic                 pred_taken;
        logic [31:0]          pred_target;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    entry_t        enq_ent;
    entry_t        head_ent;
    entry_t        out_ent;
    logic          enq_fire;
    logic          deq_fire;

    assign empty     = (head_ptr == tail_ptr);
    assign full      = (head_ptr[AW] != tail_ptr[AW]) && (head_ptr[AW-1:0] == tail_ptr[AW-1:0]);
    assign count     = tail_ptr - head_ptr;
    // Depends only on stored state, so a bypass path cannot form a loop through iq_ready.
    assign enq_ready = !full;

    always_comb begin
        enq_ent.pc          = enq_pc;
        enq_ent.inst        = enq_inst;
        enq_ent.bht_idx     = enq_bht_idx;
        enq_ent.pred_taken  = enq_pred_taken;
        enq_ent.pred_target = enq_pred_target;
    end

    assign head_ent = mem[head_ptr[AW-1:0]];

`ifdef IQ_BYPASS_EN
    logic bypass;
    logic bypass_pass;

    assign bypass      = empty && enq_valid && !flush;
    assign bypass_pass = bypass && iq_ready;
    assign iq_valid    = (!empty || enq_valid) && !flush;
    assign out_ent     = bypass ? enq_ent : head_ent;
    // A word handed straight to decode is never written.
    assign enq_fire    = enq_valid && enq_ready && !flush && !bypass_pass;
    assign deq_fire    = iq_valid && iq_ready && !empty;
`else
    assign iq_valid    = !empty && !flush;
    assign out_ent     = head_ent;
    assign enq_fire    = enq_valid && enq_ready && !flush;
    assign deq_fire    = iq_valid && iq_ready;
`endif

    assign iq_pc          = out_ent.pc;
    assign iq_inst        = out_ent.inst;
    assign iq_bht_idx     = out_ent.bht_idx;
    assign iq_pred_taken  = out_ent.pred_taken;
    assign iq_pred_target = out_ent.pred_target;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (enq_fire) tail_ptr <= tail_ptr + PW'(1);
            if (deq_fire) head_ptr <= head_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq_fire) begin
            mem[tail_ptr[AW-1:0]] <= enq_ent;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed stimulus pushes expected entries into a scoreboard,
// a negedge monitor pops and compares whenever decode takes the head.
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int BW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic [31:0]   enq_pc;
    logic [31:0]   enq_inst;
    logic [BW-1:0] enq_bht_idx;
    logic          enq_pred_taken;
    logic [31:0]   enq_pred_target;
    logic          iq_valid;
    logic          iq_ready;
    logic [31:0]   iq_pc;
    logic [31:0]   iq_inst;
    logic [BW-1:0] iq_bht_idx;
    logic          iq_pred_taken;
    logic [31:0]   iq_pred_target;
    logic [4:0]    count;
    logic          full;
    logic          empty;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic [BW-1:0] bht_idx;
        logic          pred_taken;
        logic [31:0]   pred_target;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    inst_queue #(.DEPTH(DEPTH), .BHT_IDX_W(BW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_bht_idx(enq_bht_idx),
        .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
        .iq_valid(iq_valid), .iq_ready(iq_ready),
        .iq_pc(iq_pc), .iq_inst(iq_inst), .iq_bht_idx(iq_bht_idx),
        .iq_pred_taken(iq_pred_taken), .iq_pred_target(iq_pred_target),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive entry k with the given pc; push it as expected when it will be accepted.
    task automatic drive(input int k, input logic [31:0] pc, input bit push);
        exp_t e;
        e.pc          = pc;
        e.inst        = 32'hA000_0000 | 32'(k);
        e.bht_idx     = BW'(k);
        e.pred_taken  = 1'(k & 1);
        e.pred_target = 32'h2000 + 32'(k);
        enq_valid       = 1'b1;
        enq_pc          = e.pc;
        enq_inst        = e.inst;
        enq_bht_idx     = e.bht_idx;
        enq_pred_taken  = e.pred_taken;
        enq_pred_target = e.pred_target;
        if (push) sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && iq_valid && iq_ready) begin
            exp_t act;
            act = {iq_pc, iq_inst, iq_bht_idx, iq_pred_taken, iq_pred_target};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_dequeue: got pc 0x%0h expected no transfer", iq_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL deq_entry: got pc 0x%0h inst 0x%0h bht %0d tk %0b tgt 0x%0h expected pc 0x%0h inst 0x%0h bht %0d tk %0b tgt 0x%0h",
                             act.pc, act.inst, act.bht_idx, act.pred_taken, act.pred_target,
                             e.pc, e.inst, e.bht_idx, e.pred_taken, e.pred_target);
                end
            end
            pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; iq_ready = 1'b0;
        enq_valid = 1'b0; enq_pc = '0; enq_inst = '0; enq_bht_idx = '0;
        enq_pred_taken = 1'b0; enq_pred_target = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_iq_valid", 64'(iq_valid), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_iq_pc", 64'(iq_pc), 64'd0);
        check("rst_iq_inst", 64'(iq_inst), 64'd0);

        // Fill with iq_ready low
        for (int k = 0; k < DEPTH; k++) begin
            drive(k, 32'h1000 + 32'(4 * k), 1'b1);
            if (k == 0) begin
                #1;
`ifdef IQ_BYPASS_EN
                check("fill_first_same_cycle_valid", 64'(iq_valid), 64'd1);
`else
                check("fill_first_same_cycle_valid", 64'(iq_valid), 64'd0);
`endif
            end
            tick();
            if (k == 0) begin
                check("fill_first_next_valid", 64'(iq_valid), 64'd1);
                check("fill_first_count", 64'(count), 64'd1);
            end
        end
        drive(16, 32'h1040, 1'b0);
        #1;
        check("full_count", 64'(count), 64'd16);
        check("full_flag", 64'(full), 64'd1);
        check("full_enq_ready", 64'(enq_ready), 64'd0);
        tick();
        check("overfill_count", 64'(count), 64'd16);
        enq_valid = 1'b0;

        // Drain one per cycle
        iq_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("drain_count", 64'(count), 64'(DEPTH - 1 - i));
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_pops", 64'(pops), 64'd16);
        check("drain_sb_left", 64'(sb.size()), 64'd0);

        // Streaming at occupancy 5 across pointer wrap
        iq_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(32 + k, 32'h3000 + 32'(4 * k), 1'b1);
            tick();
        end
        check("stream_pre_count", 64'(count), 64'd5);
        iq_ready = 1'b1;
        for (int k = 5; k < 45; k++) begin
            drive(32 + k, 32'h3000 + 32'(4 * k), 1'b1);
            tick();
            check("stream_count", 64'(count), 64'd5);
        end
        check("stream_pops", 64'(pops), 64'd56);
        check("stream_sb_left", 64'(sb.size()), 64'd5);

        // Grow to 9 then flush with enq and deq both requested
        iq_ready = 1'b0;
        for (int k = 45; k < 49; k++) begin
            drive(32 + k, 32'h3000 + 32'(4 * k), 1'b1);
            tick();
        end
        check("preflush_count", 64'(count), 64'd9);
        sb.delete();
        drive(99, 32'h3F00, 1'b0);
        iq_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_cycle_iq_valid", 64'(iq_valid), 64'd0);
        tick();
        flush = 1'b0; enq_valid = 1'b0; iq_ready = 1'b0;
        #1;
        check("postflush_count", 64'(count), 64'd0);
        check("postflush_iq_valid", 64'(iq_valid), 64'd0);
        check("postflush_enq_ready", 64'(enq_ready), 64'd1);
        check("postflush_empty", 64'(empty), 64'd1);
        drive(64, 32'h4000, 1'b1);
        tick();
        enq_valid = 1'b0;
        #1;
        check("postflush_enq_valid", 64'(iq_valid), 64'd1);
        check("postflush_enq_pc", 64'(iq_pc), 64'h4000);
        iq_ready = 1'b1;
        tick();
        check("postflush_drained", 64'(sb.size()), 64'd0);

        // Mid-operation reset at occupancy 7
        iq_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive(80 + k, 32'h5000 + 32'(4 * k), 1'b1);
            tick();
        end
        enq_valid = 1'b0;
        check("prereset_count", 64'(count), 64'd7);
        sb.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_iq_valid", 64'(iq_valid), 64'd0);
        check("midrst_iq_pc", 64'(iq_pc), 64'd0);
        check("midrst_iq_inst", 64'(iq_inst), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_full", 64'(full), 64'd0);
        check("midrst_enq_ready", 64'(enq_ready), 64'd1);

        // Empty queue, enq and deq together
        iq_ready = 1'b1;
        drive(0, 32'h80, 1'b1);
        #1;
`ifdef IQ_BYPASS_EN
        check("bypass_iq_valid", 64'(iq_valid), 64'd1);
        check("bypass_iq_pc", 64'(iq_pc), 64'h80);
        tick();
        enq_valid = 1'b0;
        #1;
        check("bypass_count", 64'(count), 64'd0);
        check("bypass_empty", 64'(empty), 64'd1);
`else
        check("nobypass_same_valid", 64'(iq_valid), 64'd0);
        tick();
        enq_valid = 1'b0;
        #1;
        check("nobypass_next_valid", 64'(iq_valid), 64'd1);
        check("nobypass_next_pc", 64'(iq_pc), 64'h80);
        check("nobypass_count", 64'(count), 64'd1);
        tick();
        check("nobypass_after_deq", 64'(count), 64'd0);
`endif
        check("final_sb_left", 64'(sb.size()), 64'd0);
        iq_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between fetch and decode. It buffers fetched instructions with their branch-prediction metadata (pc, inst, bht_idx, pred_taken, pred_target).
- The head entry is presented to decode over the iq_valid/iq_ready interface. Decode accepts the head when iq_valid && iq_ready.
- A pipeline flush from branch resolution empties the queue in one cycle.

Parameters:
- DEPTH, 16, number of entries; power of 2, >= 2.
- BHT_IDX_W, 8, width of the BHT index carried per entry.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries (same cycle as decode flush)
- enq_valid  in  1  fetch presents an instruction
- enq_ready  out  1  queue can accept; transfer when enq_valid && enq_ready
- enq_pc  in  32  fetch pc
- enq_inst  in  32  fetched instruction word
- enq_bht_idx  in  BHT_IDX_W  BHT index used for the prediction
- enq_pred_taken  in  1  predicted taken
- enq_pred_target  in  32  predicted target
- iq_valid  out  1  head entry valid
- iq_ready  in  1  decode accepts head; dequeue when iq_valid && iq_ready
- iq_pc  out  32  head pc
- iq_inst  out  32  head instruction
- iq_bht_idx  out  BHT_IDX_W  head BHT index
- iq_pred_taken  out  1  head prediction
- iq_pred_target  out  32  head predicted target
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Pointers: head_ptr and tail_ptr, each $clog2(DEPTH)+1 bits.
  - Index = low bits; wrap-around is natural modulo 2*DEPTH.
  - empty = pointers equal. full = MSBs differ and low bits equal.
  - count = tail_ptr - head_ptr, modulo 2*DEPTH.
- Storage: one packed entry per slot; registers reset to 0 on rst.
- enq_ready = !full.
  - Depends only on state, never on iq_ready. There is no pass-through when full.
- iq_valid = !empty && !flush. iq_* data driven combinationally from the head slot.
  - When empty, the data fields show the stale slot contents and are don't-care.
- Enqueue (enq_valid && enq_ready && !flush): write slot[tail], tail_ptr += 1.
- Dequeue (iq_valid && iq_ready): head_ptr += 1.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged. Legal at any non-full occupancy.
- Latency: an entry enqueued in cycle N is first visible on iq_valid in cycle N+1. Order is strictly FIFO.
- Flush (synchronous, highest priority after rst):
  - head_ptr <= 0 and tail_ptr <= 0.
  - Any enqueue or dequeue in the flush cycle is discarded. iq_valid is 0 during the flush cycle.
  - Next cycle: empty=1, count=0, enq_ready=1.
- rst: same as flush, plus storage cleared.
  - Outputs after reset: iq_valid=0, enq_ready=1, count=0, empty=1, full=0, all iq_* data = 0.
- Reset or flush mid-stream: no partial state survives. The next enqueue lands in slot 0.
- No state machine beyond the pointers; no other internal state.

Optional Feature:
- Macro IQ_BYPASS_EN.
- When defined and the queue is empty:
  - If enq_valid && !flush, then iq_valid=1 in the same cycle and the iq_* fields come from the enq_* inputs.
  - If iq_ready is also 1, the instruction passes straight to decode. It is not written and the pointers do not move.
  - If iq_ready is 0, it is written normally and tail advances.
  - The non-empty case is unchanged.
- This is zero-cycle latency on an empty queue. There is no combinational loop, because enq_ready depends only on full.
- When not defined: iq_valid = !empty && !flush, and latency is always 1 cycle.

Test Plan:
- Reset, then fill: enqueue 16 entries with pc 0x1000+4k, iq_ready=0.
  - Required: count reaches 16, full=1, enq_ready=0.
  - A 17th enq_valid is not accepted and count stays 16.
- Drain: iq_ready=1 on a full queue.
  - Required: iq_pc sequence 0x1000, 0x1004 … 0x103C, one per cycle.
  - Metadata (bht_idx=k, pred_taken=k[0], pred_target=0x2000+k) matches per entry; empty=1 after 16 cycles.
- Concurrent streaming at count=5: enq and deq every cycle for 40 cycles.
  - Required: count stays 5, FIFO order preserved across pointer wrap, no loss or duplication.
- Flush with count=9, issued while enq_valid=1 and iq_ready=1.
  - Required: next cycle count=0, iq_valid=0, enq_ready=1.
  - Following enqueue pc=0x4000 appears at iq_pc one cycle later.
- Mid-operation reset at count=7.
  - Required: next cycle iq_valid=0, iq_pc=0, iq_inst=0, count=0, full=0.
- IQ_BYPASS_EN, empty queue, enq_pc=0x80, iq_ready=1.
  - With bypass: iq_valid=1 and iq_pc=0x80 in the same cycle; count stays 0.
  - Without bypass: iq_valid=1 the next cycle and count=1 before the dequeue.
